// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] MIN_INT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_addsuber.sv
// Ripple adder/subtractor shared by the divider for its trial subtraction.
// In subtract mode carry_flag is the borrow (input1 < input2, unsigned).
module addsuber #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] input1,
  input  logic [BITWIDTH-1:0] input2,
  input  logic                add_or_sub,
  output logic [BITWIDTH-1:0] result,
  output logic                carry_flag,
  output logic                overflow_flag
);

  logic [BITWIDTH-1:0] operand2;
  logic                carry_out;

  // Two's-complement add of input1 and (optionally inverted) input2.
  always_comb begin
    operand2 = add_or_sub ? ~input2 : input2;
    {carry_out, result} = {1'b0, input1} + {1'b0, operand2}
                        + {{BITWIDTH{1'b0}}, add_or_sub};
    carry_flag    = add_or_sub ? ~carry_out : carry_out;
    overflow_flag = (input1[BITWIDTH-1] == operand2[BITWIDTH-1]) &&
                    (result[BITWIDTH-1] != input1[BITWIDTH-1]);
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Build option: SEQ_DIV_FASTPATH_EN sends divide-by-zero and signed overflow
// straight from IDLE to DONE; without it every operation takes the full loop.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CALC  | shift/trial-subtract loop, BITWIDTH cycles
//   DONE  | first cycle applies sign fix / forced values, then holds result until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int BITWIDTH = DIV_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_signed,
  input  logic [BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0] remainder,
  output logic                div_zero
);

  localparam int                  CNT_BITS = $clog2(BITWIDTH);
  localparam logic [BITWIDTH-1:0] MIN_VAL  = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0] ONES     = {BITWIDTH{1'b1}};
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BITWIDTH - 1);

  state_t              state;
  logic [CNT_BITS-1:0] counter;
  logic [BITWIDTH-1:0] dq;         // dividend shifting out, quotient shifting in
  logic [BITWIDTH-1:0] partial;    // running remainder
  logic [BITWIDTH-1:0] div_abs;
  logic [BITWIDTH-1:0] dvd_raw;    // original dividend, needed for divide-by-zero remainder
  logic                q_neg;
  logic                r_neg;
  logic                zero_l;
  logic                ovf_l;

  logic [BITWIDTH-1:0] dvd_abs_in;
  logic [BITWIDTH-1:0] dsr_abs_in;
  logic                zero_in;
  logic                ovf_in;
  logic [BITWIDTH-1:0] shifted;
  logic [BITWIDTH-1:0] sub_res;
  logic                borrow;
  logic                q_bit;
  logic [BITWIDTH-1:0] q_fix;
  logic [BITWIDTH-1:0] r_fix;

  // Operand magnitudes, special-case detection, shift datapath and sign fix.
  always_comb begin
    dvd_abs_in = (is_signed && dividend[BITWIDTH-1]) ? -dividend : dividend;
    dsr_abs_in = (is_signed && divisor[BITWIDTH-1])  ? -divisor  : divisor;
    zero_in    = (divisor == '0);
    ovf_in     = is_signed && (dividend == MIN_VAL) && (divisor == ONES);
    shifted    = {partial[BITWIDTH-2:0], dq[BITWIDTH-1]};
    // A bit shifted out of partial means the true partial exceeds any divisor,
    // so the subtraction must succeed even though the low bits borrowed.
    q_bit      = partial[BITWIDTH-1] | ~borrow;
    q_fix      = q_neg ? -dq : dq;
    r_fix      = r_neg ? -partial : partial;
  end

  addsuber #(.BITWIDTH(BITWIDTH)) u_addsuber (
    .input1        (shifted),
    .input2        (div_abs),
    .add_or_sub    (1'b1),
    .result        (sub_res),
    .carry_flag    (borrow),
    .overflow_flag ()
  );

  // Control FSM plus operand/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      dq        <= '0;
      partial   <= '0;
      div_abs   <= '0;
      dvd_raw   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      zero_l    <= 1'b0;
      ovf_l     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      counter   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dq       <= dvd_abs_in;
            div_abs  <= dsr_abs_in;
            dvd_raw  <= dividend;
            partial  <= '0;
            counter  <= '0;
            q_neg    <= is_signed & (dividend[BITWIDTH-1] ^ divisor[BITWIDTH-1]);
            r_neg    <= is_signed & dividend[BITWIDTH-1];
            zero_l   <= zero_in;
            ovf_l    <= ovf_in;
            in_ready <= 1'b0;
`ifdef SEQ_DIV_FASTPATH_EN
            state    <= (zero_in || ovf_in) ? DONE : CALC;
`else
            state    <= CALC;
`endif
          end
        end
        CALC: begin
          partial <= q_bit ? sub_res : shifted;
          dq      <= {dq[BITWIDTH-2:0], q_bit};
          counter <= counter + CNT_BITS'(1);
          if (counter == LAST_CNT) state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            div_zero  <= zero_l;
            if (zero_l) begin
              quotient  <= ONES;
              remainder <= dvd_raw;
            end else if (ovf_l) begin
              quotient  <= dvd_raw;
              remainder <= '0;
            end else begin
              quotient  <= q_fix;
              remainder <= r_fix;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
